// File: rtl/par_serial_tx.sv
// rtl/par_serial_tx.sv - output-channel flit serializer with valid/ready link beats

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 12
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module par_serial_tx #(
    parameter int DATA_W = `PAYLOAD_SIZE + `ADDR_SZ,
    parameter int LINK_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] item_in,
    input  logic              ena,
    output logic              busy,
    output logic [LINK_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              flit_sent
);

    // Derived geometry; the shift register is padded up to a whole number of beats.
    localparam int BEATS = (DATA_W + LINK_W - 1) / LINK_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SH_W  = BEATS * LINK_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]      state;
    logic [SH_W-1:0] shift_reg;
    logic [CNT_W-1:0] beat_cnt;
    logic            last_beat;

    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    // Status and beat decode; everything here depends only on registered state.
    always_comb begin
        busy     = (state == S_SEND);
        tx_valid = (state == S_SEND);
        tx_last  = (state == S_SEND) && last_beat;
        tx_data  = (state == S_SEND) ? shift_reg[LINK_W-1:0] : '0;
    end

    // Capture on accept, shift out LSB-first on each transfer, pulse flit_sent after the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
            flit_sent <= 1'b0;
        end else begin
            flit_sent <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        state     <= S_SEND;
                        shift_reg <= SH_W'(item_in);
                        beat_cnt  <= '0;
                    end
                end
                S_SEND: begin
                    // ena is ignored here: the router gates it with !busy.
                    if (tx_ready) begin
                        if (last_beat) begin
                            state     <= S_IDLE;
                            flit_sent <= 1'b1;
                            shift_reg <= '0;
                            beat_cnt  <= '0;
                        end else begin
                            shift_reg <= shift_reg >> LINK_W;
                            beat_cnt  <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_serial_tx.sv
// tb/tb_par_serial_tx.sv - directed self-checking bench for par_serial_tx

module tb_par_serial_tx;

    logic        clk;
    logic        reset;

    logic [19:0] item_in;
    logic        ena;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        flit_sent;

    logic [19:0] item2;
    logic        ena2;
    logic        busy2;
    logic [31:0] data2;
    logic        valid2;
    logic        last2;
    logic        ready2;
    logic        sent2;

    int checks;
    int errors;
    int busy_cnt;

    par_serial_tx #(.DATA_W(20), .LINK_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .item_in   (item_in),
        .ena       (ena),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .flit_sent (flit_sent)
    );

    par_serial_tx #(.DATA_W(20), .LINK_W(32)) dut_wide (
        .clk       (clk),
        .reset     (reset),
        .item_in   (item2),
        .ena       (ena2),
        .busy      (busy2),
        .tx_data   (data2),
        .tx_valid  (valid2),
        .tx_last   (last2),
        .tx_ready  (ready2),
        .flit_sent (sent2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_busy"},  32'(busy),     32'd1);
        check({tag, "_data"},  32'(tx_data),  32'(d));
        check({tag, "_last"},  32'(tx_last),  32'(l));
    endtask

    task automatic check_idle(input string tag, input logic sent);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(tx_valid),  32'd0);
        check({tag, "_last"},  32'(tx_last),   32'd0);
        check({tag, "_data"},  32'(tx_data),   32'd0);
        check({tag, "_sent"},  32'(flit_sent), 32'(sent));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        ena      = 1'b0;
        item_in  = '0;
        tx_ready = 1'b1;
        ena2     = 1'b0;
        item2    = '0;
        ready2   = 1'b1;

        step();
        step();
        check_idle("in_reset", 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("idle", 1'b0);
        end

        // Basic serialization
        ena = 1'b1; item_in = 20'hABCDE;
        step();
        ena = 1'b0;
        check_beat("basic_b0", 8'hDE, 1'b0);
        check("basic_b0_sent", 32'(flit_sent), 32'd0);
        step();
        check_beat("basic_b1", 8'hBC, 1'b0);
        step();
        check_beat("basic_b2", 8'h0A, 1'b1);
        step();
        check_idle("basic_done", 1'b1);
        step();
        check_idle("basic_after", 1'b0);

        // Backpressure: three stalled cycles on beat 1
        busy_cnt = 0;
        ena = 1'b1; item_in = 20'hABCDE;
        step();
        ena = 1'b0;
        if (busy) busy_cnt++;
        check_beat("bp_b0", 8'hDE, 1'b0);
        step();
        if (busy) busy_cnt++;
        check_beat("bp_b1", 8'hBC, 1'b0);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) busy_cnt++;
            check_beat("bp_stall", 8'hBC, 1'b0);
            if (i == 2) tx_ready = 1'b1;
        end
        step();
        if (busy) busy_cnt++;
        check_beat("bp_b2", 8'h0A, 1'b1);
        step();
        check_idle("bp_done", 1'b1);
        check("bp_busy_cycles", 32'(busy_cnt), 32'd6);

        // Back-to-back flits, with an ignored ena while busy
        ena = 1'b1; item_in = 20'h12345;
        step();
        check_beat("a_b0", 8'h45, 1'b0);
        item_in = 20'hFFFFF;
        step();
        ena = 1'b0;
        check_beat("a_b1", 8'h23, 1'b0);
        step();
        check_beat("a_b2", 8'h01, 1'b1);
        step();
        check_idle("a_gap", 1'b1);
        ena = 1'b1; item_in = 20'h6789A;
        step();
        ena = 1'b0;
        check_beat("b_b0", 8'h9A, 1'b0);
        step();
        check_beat("b_b1", 8'h78, 1'b0);
        step();
        check_beat("b_b2", 8'h06, 1'b1);
        step();
        check_idle("b_done", 1'b1);
        step();
        check_idle("no_extra", 1'b0);

        // Asynchronous reset during beat 1
        ena = 1'b1; item_in = 20'hABCDE;
        step();
        ena = 1'b0;
        check_beat("rst_b0", 8'hDE, 1'b0);
        step();
        check_beat("rst_b1", 8'hBC, 1'b0);
        reset = 1'b0;
        #1;
        check_idle("rst_async", 1'b0);
        step();
        reset = 1'b1;
        check_idle("rst_held", 1'b0);
        ena = 1'b1; item_in = 20'h13579;
        step();
        ena = 1'b0;
        check_beat("rst_restart_b0", 8'h79, 1'b0);
        step();
        check_beat("rst_restart_b1", 8'h35, 1'b0);
        step();
        check_beat("rst_restart_b2", 8'h01, 1'b1);
        step();
        check_idle("rst_restart_done", 1'b1);

        // Single-beat geometry
        check("wide_idle_data", data2, 32'h0);
        check("wide_idle_valid", 32'(valid2), 32'd0);
        ena2 = 1'b1; item2 = 20'hABCDE;
        step();
        ena2 = 1'b0;
        check("wide_data", data2, 32'h000ABCDE);
        check("wide_valid", 32'(valid2), 32'd1);
        check("wide_last", 32'(last2), 32'd1);
        check("wide_busy", 32'(busy2), 32'd1);
        step();
        check("wide_done_busy", 32'(busy2), 32'd0);
        check("wide_done_sent", 32'(sent2), 32'd1);
        check("wide_done_data", data2, 32'h0);
        step();
        check("wide_after_sent", 32'(sent2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
